ps2_input_mapper: RTL



---
 rtl/input_pkg.sv | 37 +++
 rtl/ps2_input_mapper_if.sv | 26 ++
 rtl/pulse_stretcher.sv | 35 +++
 rtl/ps2_input_mapper.sv | 97 +++++++++
 4 files changed

// File: rtl/input_pkg.sv
// rtl/input_pkg.sv - shared button indices, PS/2 set-2 codes and default key map
package input_pkg;

    localparam int BTN_RIGHT  = 0;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_UP     = 3;
    localparam int BTN_FIRE   = 4;
    localparam int BTN_JUMP   = 5;
    localparam int BTN_START1 = 6;
    localparam int BTN_START2 = 7;
    localparam int BTN_COIN   = 8;

    localparam int NUM_DEFAULT_KEYS = 9;

    // {extended, scancode}
    typedef logic [8:0] ps2_code_t;

    localparam ps2_code_t KEY_RIGHT = 9'h174;
    localparam ps2_code_t KEY_LEFT  = 9'h16B;
    localparam ps2_code_t KEY_DOWN  = 9'h172;
    localparam ps2_code_t KEY_UP    = 9'h175;
    localparam ps2_code_t KEY_LCTRL = 9'h014;
    localparam ps2_code_t KEY_LALT  = 9'h011;
    localparam ps2_code_t KEY_1     = 9'h016;
    localparam ps2_code_t KEY_2     = 9'h01E;
    localparam ps2_code_t KEY_5     = 9'h02E;
    localparam ps2_code_t KEY_SPACE = 9'h029;
    localparam ps2_code_t KEY_KP8   = 9'h075;

    // Entry i lands in bits [9i+8:9i], so the last item in the concatenation is button 0.
    function automatic logic [NUM_DEFAULT_KEYS*9-1:0] default_map();
        return {KEY_5, KEY_2, KEY_1, KEY_LALT, KEY_LCTRL,
                KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT};
    endfunction

endpackage

// File: rtl/ps2_input_mapper_if.sv
// rtl/ps2_input_mapper_if.sv - key stream, joystick, map write bus and button outputs
interface ps2_input_mapper_if #(
    parameter int NUM_KEYS = 9
);
    localparam int ADDR_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic [10:0]         ps2_key;
    logic [NUM_KEYS-1:0] joystick;
    logic                map_we;
    logic [ADDR_W-1:0]   map_addr;
    logic [8:0]          map_code;
    logic                clear;
    logic [NUM_KEYS-1:0] keys;
    logic [NUM_KEYS-1:0] key_rise;

    modport master (
        output ps2_key, joystick, map_we, map_addr, map_code, clear,
        input  keys, key_rise
    );

    modport slave (
        input  ps2_key, joystick, map_we, map_addr, map_code, clear,
        output keys, key_rise
    );

endinterface

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - holds a rising input high for at least PULSE cycles
module pulse_stretcher #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] PULSE = WIDTH'(16)
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             in_d;
    logic [WIDTH-1:0] cnt;

    // Load PULSE-1 on each rising edge (reloading mid-count), else count down to zero.
    // The caller ORs its own registered copy of the input, which supplies the first cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_d <= 1'b0;
            cnt  <= '0;
        end else begin
            in_d <= in;
            if ((PULSE != '0) && in && !in_d) begin
                cnt <= PULSE - ONE;
            end else if (cnt != '0) begin
                cnt <= cnt - ONE;
            end
        end
    end

    assign out = (cnt != '0);

endmodule

// File: rtl/ps2_input_mapper.sv
// rtl/ps2_input_mapper.sv - remappable PS/2 key to button mapper merged with joystick
module ps2_input_mapper
    import input_pkg::*;
#(
    parameter int                    NUM_KEYS    = 9,
    parameter logic [NUM_KEYS*9-1:0] DEFAULT_MAP = default_map(),
    parameter int                    COIN_INDEX  = BTN_COIN,
    parameter logic [15:0]           COIN_PULSE  = 16'd4800
) (
    input  logic               clk,
    input  logic               reset,
    ps2_input_mapper_if.slave  bus
);

    localparam int ADDR_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    ps2_code_t           map_q [NUM_KEYS];
    logic                toggle_q;
    logic                key_event;
    logic [NUM_KEYS-1:0] kb_state;
    logic [NUM_KEYS-1:0] merged;
    logic [NUM_KEYS-1:0] keys_next;
    logic [NUM_KEYS-1:0] keys_q;
    logic [NUM_KEYS-1:0] rise_q;
    logic                coin_stretch;

    assign key_event = bus.ps2_key[10] ^ toggle_q;

    // Track the toggle bit every cycle, reset included, so reset never leaves a stale edge.
    always_ff @(posedge clk) begin
        toggle_q <= bus.ps2_key[10];
    end

    // Map storage; addresses past the last button never match and are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                map_q[i] <= DEFAULT_MAP[9*i +: 9];
            end
        end else if (bus.map_we) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (bus.map_addr == ADDR_W'(i)) begin
                    map_q[i] <= bus.map_code;
                end
            end
        end
    end

    // Keyboard-held state: every entry equal to the event code follows the pressed bit;
    // clear overrides any event, and a same-cycle map write is not yet visible here.
    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            kb_state <= '0;
        end else if (key_event) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (map_q[i] == bus.ps2_key[8:0]) begin
                    kb_state[i] <= bus.ps2_key[9];
                end
            end
        end
    end

    assign merged = kb_state | bus.joystick;

    pulse_stretcher #(
        .WIDTH (16),
        .PULSE (COIN_PULSE)
    ) u_coin_stretch (
        .clk   (clk),
        .reset (reset),
        .in    (merged[COIN_INDEX]),
        .out   (coin_stretch)
    );

    // Next button value: joystick passes straight through even while in reset.
    always_comb begin
        keys_next             = merged;
        keys_next[COIN_INDEX] = merged[COIN_INDEX] | coin_stretch;
        if (reset) begin
            keys_next = bus.joystick;
        end
    end

    // Register buttons and their rising-edge strobes on the same edge so they line up.
    always_ff @(posedge clk) begin
        keys_q <= keys_next;
        if (reset) begin
            rise_q <= '0;
        end else begin
            rise_q <= keys_next & ~keys_q;
        end
    end

    assign bus.keys     = keys_q;
    assign bus.key_rise = rise_q;

endmodule
